// File: rtl/snoop_bus_ctrl.sv
// Snooping-bus controller for the MSI multicore cache system: round-robin arbitration,
// snoop/invalidate broadcast and cache-to-cache or dmem data sourcing.
module snoop_bus_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 11,
    parameter int MEM_LAT   = 4,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        rd_miss,
    input  logic [NUM_CORES-1:0]        wr_miss,
    input  logic [NUM_CORES-1:0]        inv_req,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES-1:0]        snoop_hit,
    output logic [NUM_CORES-1:0]        grant,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [NUM_CORES-1:0]        snoop_req,
    output logic [NUM_CORES-1:0]        snoop_inv,
    output logic                        fwd_valid,
    output logic [IDX_W-1:0]            fwd_src,
    output logic                        mem_rd,
    output logic                        mem_inv,
    output logic [NUM_CORES-1:0]        done,
    output logic                        busy
);

    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SNOOP = 3'd1,
        ST_INV   = 3'd2,
        ST_XFER  = 3'd3,
        ST_MEM   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_INV = 2'd2
    } op_t;

    function automatic logic [NUM_CORES-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CORES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        return IDX_W'((int'(base) + off) % NUM_CORES);
    endfunction

    state_t                 state_r, state_s;
    op_t                    op_r, op_s;
    logic [IDX_W-1:0]       win_r, win_s, rr_r, rr_s, fsrc_r, fsrc_s;
    logic [ADDR_W-1:0]      addr_r, addr_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [NUM_CORES-1:0]   req_any_s, hit_m_s, others_s;
    logic [IDX_W-1:0]       pick_s, low_s;

    logic [NUM_CORES-1:0]   grant_r, grant_s, sreq_r, sreq_s, sinv_r, sinv_s, done_r, done_s;
    logic [ADDR_W-1:0]      baddr_r, baddr_s;
    logic [IDX_W-1:0]       fsrc_o_r, fsrc_o_s;
    logic                   fwdv_r, fwdv_s, memrd_r, memrd_s, meminv_r, meminv_s, busy_r, busy_s;

    // Arbiter and snoop-hit priority: scanning downward lets the lowest offset win.
    always_comb begin
        req_any_s = rd_miss | wr_miss | inv_req;
        hit_m_s   = snoop_hit & ~idx_onehot(win_r);
        pick_s    = rr_r;
        low_s     = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (req_any_s[wrap_idx(rr_r, k)]) begin
                pick_s = wrap_idx(rr_r, k);
            end else begin
                pick_s = pick_s;
            end
        end
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            if (hit_m_s[j]) begin
                low_s = IDX_W'(j);
            end else begin
                low_s = low_s;
            end
        end
    end

    // Next-state and latched transaction context.
    always_comb begin
        state_s = state_r;
        op_s    = op_r;
        win_s   = win_r;
        addr_s  = addr_r;
        fsrc_s  = fsrc_r;
        cnt_s   = cnt_r;
        rr_s    = rr_r;
        case (state_r)
            ST_IDLE: begin
                if (|req_any_s) begin
                    win_s  = pick_s;
                    addr_s = req_addr[int'(pick_s)*ADDR_W +: ADDR_W];
                    if (inv_req[pick_s]) begin
                        op_s    = OP_INV;
                        state_s = ST_INV;
                    end else if (wr_miss[pick_s]) begin
                        op_s    = OP_WR;
                        state_s = ST_SNOOP;
                    end else begin
                        op_s    = OP_RD;
                        state_s = ST_SNOOP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SNOOP: begin
                cnt_s = '0;
                if (|hit_m_s) begin
                    fsrc_s  = low_s;
                    state_s = ST_XFER;
                end else begin
                    state_s = ST_MEM;
                end
            end
            ST_XFER: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_MEM: begin
                if (cnt_r == CNT_W'(MEM_LAT - 1)) begin
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_INV: begin
                state_s = ST_DONE;
            end
            ST_DONE: begin
                cnt_s   = '0;
                rr_s    = (win_r == IDX_W'(NUM_CORES - 1)) ? '0 : win_r + IDX_W'(1);
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from next state so every port comes straight from a flop.
    always_comb begin
        grant_s  = '0;
        baddr_s  = '0;
        sreq_s   = '0;
        sinv_s   = '0;
        fwdv_s   = 1'b0;
        fsrc_o_s = '0;
        memrd_s  = 1'b0;
        meminv_s = 1'b0;
        done_s   = '0;
        busy_s   = 1'b0;
        others_s = ~idx_onehot(win_s);
        if (state_s != ST_IDLE) begin
            grant_s = idx_onehot(win_s);
            baddr_s = addr_s;
            busy_s  = 1'b1;
        end else begin
            busy_s  = 1'b0;
        end
        case (state_s)
            ST_SNOOP: begin
                sreq_s = others_s;
                sinv_s = (op_s == OP_WR) ? others_s : '0;
            end
            ST_INV: begin
                sinv_s   = others_s;
                meminv_s = 1'b1;
            end
            ST_XFER: begin
                fwdv_s   = 1'b1;
                fsrc_o_s = fsrc_s;
            end
            ST_MEM:  memrd_s = 1'b1;
            ST_DONE: done_s  = idx_onehot(win_s);
            default: busy_s  = busy_s;
        endcase
    end

    // State, context and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_RD;
            win_r    <= '0;
            rr_r     <= '0;
            fsrc_r   <= '0;
            addr_r   <= '0;
            cnt_r    <= '0;
            grant_r  <= '0;
            baddr_r  <= '0;
            sreq_r   <= '0;
            sinv_r   <= '0;
            fwdv_r   <= 1'b0;
            fsrc_o_r <= '0;
            memrd_r  <= 1'b0;
            meminv_r <= 1'b0;
            done_r   <= '0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            op_r     <= op_s;
            win_r    <= win_s;
            rr_r     <= rr_s;
            fsrc_r   <= fsrc_s;
            addr_r   <= addr_s;
            cnt_r    <= cnt_s;
            grant_r  <= grant_s;
            baddr_r  <= baddr_s;
            sreq_r   <= sreq_s;
            sinv_r   <= sinv_s;
            fwdv_r   <= fwdv_s;
            fsrc_o_r <= fsrc_o_s;
            memrd_r  <= memrd_s;
            meminv_r <= meminv_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
        end
    end

    assign grant     = grant_r;
    assign bus_addr  = baddr_r;
    assign snoop_req = sreq_r;
    assign snoop_inv = sinv_r;
    assign fwd_valid = fwdv_r;
    assign fwd_src   = fsrc_o_r;
    assign mem_rd    = memrd_r;
    assign mem_inv   = meminv_r;
    assign done      = done_r;
    assign busy      = busy_r;

endmodule

// File: doc/snoop_bus_ctrl.md
# snoop_bus_ctrl

Parametrised snooping-bus controller for the multicore MSI cache system; successor to the two-core bus FSM, generalised to `NUM_CORES` cores. It does three things:
- Round-robin arbitration across cores, replacing the fixed cpu0-first priority.
- Snoop and invalidate broadcast to all non-granted cores.
- Data-source selection, either cache-to-cache forwarding or a counted `MEM_LAT`-cycle dmem read, with a completion pulse to the requester.

It sits between the per-core d-cache controllers and the shared dmem.

## Interface
Parameters:
- `NUM_CORES`, 4: number of cores, ≥2.
- `ADDR_W`, 11: full block address width.
- `MEM_LAT`, 4: dmem read latency in cycles, ≥1.
- `IDX_W`, `$clog2(NUM_CORES)`: core index width (derived).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rd_miss`  in  NUM_CORES  per-core read-miss request, level, held until `done`.
- `wr_miss`  in  NUM_CORES  per-core write-miss request, level.
- `inv_req`  in  NUM_CORES  per-core invalidate request (write hit to a Shared block), level.
- `req_addr`  in  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
- `snoop_hit`  in  NUM_CORES  per-core response: valid copy of `bus_addr` present; combinational in the cycle `snoop_req` is high.
- `grant`  out  NUM_CORES  one-hot bus ownership.
- `bus_addr`  out  ADDR_W  latched address of the granted request.
- `snoop_req`  out  NUM_CORES  search request to non-granted cores.
- `snoop_inv`  out  NUM_CORES  invalidate-copy command to non-granted cores.
- `fwd_valid`  out  1  data sourced from another core's cache.
- `fwd_src`  out  IDX_W  index of the forwarding core.
- `mem_rd`  out  1  dmem read in progress.
- `mem_inv`  out  1  dmem invalidate pulse.
- `done`  out  NUM_CORES  one-cycle completion pulse to the requester.
- `busy`  out  1  FSM not in IDLE.

## Operation
States: IDLE, SNOOP, INV, XFER, MEM, DONE.

- **IDLE.** A core is requesting if `rd_miss|wr_miss|inv_req` is set.
  - Pick winner w as the first requesting core at or after `rr_ptr`, scanning upward modulo NUM_CORES.
  - Op priority within w: `inv_req` > `wr_miss` > `rd_miss`.
  - Latch w, the op, and `req_addr[w]`.
  - Next state: INV for invalidate, SNOOP otherwise.
- **SNOOP (1 cycle).**
  - `snoop_req[j]=1` for all j≠w.
  - On a write miss, `snoop_inv[j]=1` for all j≠w as well.
  - Sample `snoop_hit` with bit w masked.
  - Any hit: record `fwd_src` = lowest-index hitting core, go to XFER. No hit: go to MEM.
- **XFER (exactly 2 cycles).** `fwd_valid=1`, `fwd_src` stable; then DONE.
- **MEM (MEM_LAT cycles).** `mem_rd=1`. The latency counter loads 0 on entry, increments each cycle, and exits to DONE when count == MEM_LAT-1.
- **INV (1 cycle).** `snoop_inv[j]=1` for all j≠w, `mem_inv=1`; then DONE.
- **DONE (1 cycle).** `done[w]=1`; `rr_ptr` ← (w+1) mod NUM_CORES; then IDLE.

Bus holding and masking rules:
- `grant[w]` and `bus_addr` are held from SNOOP/INV through DONE inclusive.
- In IDLE, `grant=0` and `bus_addr=0`.
- Requests from other cores, and deassertion of w's own request, are ignored until IDLE.
- The state machine and datapath outputs are registered. `grant`, `bus_addr`, `snoop_req`, `snoop_inv`, `fwd_valid`, `fwd_src`, `mem_rd`, `mem_inv`, `done` and `busy` are all driven from state and latched values, not from current inputs.

## Timing
- **Reset.** All outputs 0; state IDLE; `rr_ptr` 0; latency counter 0. Assertion mid-operation aborts immediately: no `done` is issued, and the core must re-request.
- **Request-to-done latency**, with the request visible in IDLE at cycle 0:
  - Invalidate: INV at c1, `done` at c2.
  - Read or write miss with a snoop hit: SNOOP c1, XFER c2–c3, `done` c4.
  - Read or write miss with no hit: SNOOP c1, MEM c2..c(1+MEM_LAT), `done` c(2+MEM_LAT).
- **Back-to-back.** After DONE the FSM spends 1 cycle in IDLE before the next grant. Minimum gap between consecutive `done` pulses is 3 cycles.
- **Simultaneous requests.** Exactly one grant at a time. Round-robin guarantees every requesting core is granted within NUM_CORES transactions.
- **Multiple `snoop_hit`.** The lowest index wins, and the choice is deterministic.
- **`snoop_hit` outside SNOOP** is ignored.
- **`MEM_LAT`=1.** MEM lasts a single cycle.

## Test plan
- **Reset then single read miss, no hit.** Config: NUM_CORES=4, MEM_LAT=4. `rd_miss[2]=1`, `req_addr[2]=11'h155`, no `snoop_hit`.
  - c1: `grant=4'b0100`, `snoop_req=4'b1011`, `bus_addr=11'h155`.
  - `mem_rd` high c2–c5.
  - `done=4'b0100` at c6.
- **Read miss with forwarding.** `rd_miss[0]=1`; `snoop_hit=4'b1010` in SNOOP.
  - `fwd_valid=1`, `fwd_src=1` for exactly 2 cycles.
  - `mem_rd` never asserted.
  - `done[0]` at c4.
- **Write miss.** `wr_miss[3]=1`, addr `11'h7FF`.
  - SNOOP: `snoop_req=4'b0111` and `snoop_inv=4'b0111`.
  - Then MEM, then `done[3]`.
- **Invalidate priority.** `inv_req[1]`, `wr_miss[1]` and `rd_miss[1]` all set.
  - INV at c1 with `snoop_inv=4'b1101` and `mem_inv=1`.
  - `done[1]` at c2.
- **Round-robin fairness.** All four cores hold `rd_miss` with no hits.
  - Grant order is 0,1,2,3,0.
  - `grant` is always one-hot; `rr_ptr` wraps 3→0.
- **Reset mid-MEM.** Drop `rst_n` during MEM cycle 2.
  - All outputs are 0 immediately.
  - After release, a held request is re-granted starting from core 0.
